// File: rtl/rlm_pkg.sv
// Shared types and defaults for run_length_meter: run record, FSM state and
// the power-of-two helper used to validate the FIFO depth.
package rlm_pkg;

  localparam int unsigned RLM_CNT_W = 16;
  localparam int unsigned RLM_DEPTH = 4;

  typedef struct packed {
    logic                 level;
    logic [RLM_CNT_W-1:0] len;
  } rlm_rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rlm_state_e;

  function automatic logic is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/rlm_fifo.sv
// Synchronous record FIFO for run_length_meter. The caller guarantees no push
// when full and no pop when empty; a simultaneous push and pop on a full FIFO is legal.
module rlm_fifo
  import rlm_pkg::*;
#(
  parameter type         rec_t = rlm_rec_t,
  parameter int unsigned DEPTH = RLM_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  rec_t wr_data,
  output logic full,
  output logic empty,
  output rec_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("rlm_fifo: DEPTH must be a power of two and at least 2");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/run_length_meter.sv
// Measures the length of each constant-level run on din and queues {level, length}
// records behind a valid/ready port. Optional macro RLM_SAT_SPLIT_EN splits
// saturated runs into max-length records instead of saturating silently.
module run_length_meter
  import rlm_pkg::*;
#(
  parameter int unsigned CNT_W = RLM_CNT_W,
  parameter int unsigned DEPTH = RLM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_level,
  output logic [CNT_W-1:0] out_len,
  output logic             overflow
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("run_length_meter: CNT_W must be at least 1");
  end

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
  } rec_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rlm_state_e       state_q, state_d;
  logic             cur_level_q, cur_level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic rec_push;
  rec_t rec;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  rec_t fifo_head;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cur_level_d = cur_level_q;
    count_d     = count_q;
    rec_push    = 1'b0;
    rec         = '{level: cur_level_q, len: count_q};

    unique case (state_q)
      IDLE: begin
        cur_level_d = din;
        count_d     = CNT_W'(1);
        state_d     = RUN;
      end
      RUN: begin
        if (din != cur_level_q) begin
          rec_push    = 1'b1;
          cur_level_d = din;
          count_d     = CNT_W'(1);
        end else if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
`ifdef RLM_SAT_SPLIT_EN
        else begin
          // Close out a max-length chunk; the current sample starts the next one.
          rec_push = 1'b1;
          count_d  = CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = rec_push && (!fifo_full || fifo_pop);
  assign drop       = rec_push && fifo_full && !fifo_pop;
  assign overflow_d = drop ? 1'b1 : (clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_level_q <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_level_q <= cur_level_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  rlm_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Head fields are forced to 0 while empty so stale storage never shows.
  assign out_valid = !fifo_empty;
  assign out_level = fifo_empty ? 1'b0 : fifo_head.level;
  assign out_len   = fifo_empty ? '0 : fifo_head.len;
  assign overflow  = overflow_q;

endmodule
